cpu_sequencer: RTL
==================

// Module: cpu_sequencer
// PURPOSE
//  Top-level instruction sequencer for the multicycle MIPS core. Owns the 3-bit state consumed by
//  the control decoder (0=fetch, 2=execute) and stalls on bus waitrequest and multi-cycle mult/div.
//  Emits IR-load, PC-update and commit strobes, and detects halt (jump to address 0).
// PARAMETERS
//  MULT_CYCLES  4   cycles spent in MD_WAIT for MULT/MULTU (legal 1..63)
//  DIV_CYCLES   32  cycles spent in MD_WAIT for DIV/DIVU (legal 1..63)
// PORTS
//  clk          in   1   core clock
//  reset        in   1   synchronous, active-high reset
//  waitrequest  in   1   bus stall; current read/write not yet accepted
//  mem_read     in   1   decoder read request (fetch or load)
//  mem_write    in   1   decoder write request (store)
//  multdiv      in   1   decoder flag: instruction is MULT/MULTU/DIV/DIVU
//  is_div       in   1   with multdiv: 1=DIV/DIVU, 0=MULT/MULTU
//  pc_next      in   32  PC selected for the next instruction
//  state        out  3   0 FETCH, 1 DECODE, 2 EXEC, 4 MD_WAIT, 7 HALTED
//  active       out  1   1 until halt
//  ir_load      out  1   latch readdata into IR this cycle
//  pc_update    out  1   load pc_next into PC this cycle
//  commit       out  1   qualifies reg_write_enable and hi/lo MT writes
//  hilo_commit  out  1   qualifies mult/div result write into hi/lo
//  stall        out  1   1 while waiting on waitrequest or MD timer
// BEHAVIOUR
//  - Reset: state=FETCH, active=1, all strobes 0, MD counter 0; applies from any state, mid-access or mid-MD.
//  - Strobes combinational from registered state + inputs; state changes only on clk rising edge.
//  - FETCH: waitrequest=1 -> stay, stall=1; waitrequest=0 -> ir_load=1, next DECODE.
//  - DECODE: one cycle, register-file read; waitrequest ignored; next EXEC.
//  - EXEC, (mem_read|mem_write)&waitrequest: stay, stall=1, commit=0, pc_update=0.
//    Read and write both set -> one access; waitrequest rule unchanged.
//  - EXEC, not stalled, multdiv=0: commit=1, pc_update=1; next HALTED if pc_next==0 else FETCH.
//  - EXEC, not stalled, multdiv=1: commit=0; load counter with is_div?DIV_CYCLES:MULT_CYCLES; next MD_WAIT.
//  - MD_WAIT: stall=1; counter decrements each cycle. At counter==1: stall=0, hilo_commit=1,
//    pc_update=1; next HALTED/FETCH on pc_next rule. Total cycles in MD_WAIT = loaded value.
//  - HALTED: active=0, all strobes 0, absorbing until reset; waitrequest/requests ignored.
//  - Encodings 3,5,6 unreachable; if entered -> next FETCH, strobes 0.
//  - Latency, no stalls: 3 cycles/instr (FETCH,DECODE,EXEC); mult/div adds N cycles.
// CONFIGURATION
//  SEQ_PERF_CNT_EN defined: extra outputs cycle_count[31:0] (+1 each cycle while active) and
//   instr_count[31:0] (+1 on each pc_update); both 0 on reset, wrap at 2^32, frozen in HALTED.
//  Not defined: ports and counters absent; no other behavioural difference.
// STRUCTURE
//  - cpu_pkg: seq_state_t enum (FETCH=0, DECODE=1, EXEC=2, MD_WAIT=4, HALTED=7), HALT_ADDR=32'h0,
//    MD_CNT_W=6. The control decoder imports the same encodings.
//  - One sub-module md_timer: loadable 6-bit down-counter with load/value inputs and a last flag
//    (count==1); owns the MD counter.
// TESTING
//  - ADDU, waitrequest=0 throughout -> states 0,1,2,0; ir_load at cycle0, commit+pc_update at cycle2.
//  - Fetch with waitrequest high 3 cycles -> FETCH held 4 cycles, stall=1 x3, single ir_load pulse.
//  - LW in EXEC, waitrequest high 2 cycles -> EXEC held 3 cycles, commit=0 until 3rd, then 1 for 1 cycle.
//  - DIV, DIV_CYCLES=32 -> 32 cycles MD_WAIT, hilo_commit+pc_update on 32nd only, commit=0 throughout.
//  - JR with pc_next=0 -> HALTED after EXEC, active=0, stays with waitrequest/mem_read toggling.
//  - reset asserted mid MD_WAIT (count=10) -> FETCH next edge, strobes 0; next MULT uses MULT_CYCLES.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared sequencer encodings and constants; imported by the sequencer and the control decoder.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXEC    = 3'd2,
        MD_WAIT = 3'd4,
        HALTED  = 3'd7
    } seq_state_t;

    localparam logic [31:0] HALT_ADDR = 32'h0;
    localparam int          MD_CNT_W  = 6;

    function automatic logic [MD_CNT_W-1:0] md_load_value(input logic is_div,
                                                          input int   mult_cycles,
                                                          input int   div_cycles);
        return is_div ? MD_CNT_W'(div_cycles) : MD_CNT_W'(mult_cycles);
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Decoder/bus-side handshake bundle of the instruction sequencer.
interface cpu_sequencer_if;

    logic        waitrequest;
    logic        mem_read;
    logic        mem_write;
    logic        multdiv;
    logic        is_div;
    logic [31:0] pc_next;

    logic [2:0]  state;
    logic        active;
    logic        ir_load;
    logic        pc_update;
    logic        commit;
    logic        hilo_commit;
    logic        stall;

    modport master (
        input  waitrequest, mem_read, mem_write, multdiv, is_div, pc_next,
        output state, active, ir_load, pc_update, commit, hilo_commit, stall
    );

    modport slave (
        output waitrequest, mem_read, mem_write, multdiv, is_div, pc_next,
        input  state, active, ir_load, pc_update, commit, hilo_commit, stall
    );

endinterface

// File: rtl/cpu_sequencer_md_timer.sv
// Loadable down-counter timing MULT/DIV occupancy; last flags the final MD_WAIT cycle.
module md_timer
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [MD_CNT_W-1:0] value,
    output logic                last
);

    logic [MD_CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - MD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == MD_CNT_W'(1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle MIPS instruction sequencer: FETCH/DECODE/EXEC with bus and mult/div stalls, halt on jump to 0.
// Optional SEQ_PERF_CNT_EN adds cycle_count/instr_count outputs.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic            clk,
    input  logic            reset,
    cpu_sequencer_if.master bus
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0]     cycle_count,
    output logic [31:0]     instr_count
`endif
);

    seq_state_t          state_q, state_d;
    logic                ir_load, pc_update, commit, hilo_commit, stall;
    logic                md_load, md_last;
    logic [MD_CNT_W-1:0] md_value;
    logic                mem_req, halt_next;

    assign mem_req   = bus.mem_read | bus.mem_write;
    assign halt_next = (bus.pc_next == HALT_ADDR);
    assign md_value  = md_load_value(bus.is_div, MULT_CYCLES, DIV_CYCLES);

    always_comb begin
        state_d     = state_q;
        ir_load     = 1'b0;
        pc_update   = 1'b0;
        commit      = 1'b0;
        hilo_commit = 1'b0;
        stall       = 1'b0;
        md_load     = 1'b0;
        case (state_q)
            FETCH: begin
                if (bus.waitrequest) begin
                    stall = 1'b1;
                end else begin
                    ir_load = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                if (mem_req && bus.waitrequest) begin
                    stall = 1'b1;
                end else if (bus.multdiv) begin
                    md_load = 1'b1;
                    state_d = MD_WAIT;
                end else begin
                    commit    = 1'b1;
                    pc_update = 1'b1;
                    state_d   = halt_next ? HALTED : FETCH;
                end
            end
            MD_WAIT: begin
                if (md_last) begin
                    hilo_commit = 1'b1;
                    pc_update   = 1'b1;
                    state_d     = halt_next ? HALTED : FETCH;
                end else begin
                    stall = 1'b1;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = FETCH;
        endcase
        // Strobes are combinational, so reset must mask them in the cycle it is asserted.
        if (reset) begin
            ir_load     = 1'b0;
            pc_update   = 1'b0;
            commit      = 1'b0;
            hilo_commit = 1'b0;
            stall       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    md_timer u_md_timer (
        .clk   (clk),
        .reset (reset),
        .load  (md_load),
        .value (md_value),
        .last  (md_last)
    );

    assign bus.state       = state_q;
    assign bus.active      = (state_q != HALTED);
    assign bus.ir_load     = ir_load;
    assign bus.pc_update   = pc_update;
    assign bus.commit      = commit;
    assign bus.hilo_commit = hilo_commit;
    assign bus.stall       = stall;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] instr_count_q, instr_count_d;

    always_comb begin
        cycle_count_d = cycle_count_q;
        instr_count_d = instr_count_q;
        if (state_q != HALTED) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
        if (pc_update) begin
            instr_count_d = instr_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_q <= '0;
            instr_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;
`endif

endmodule
